arb8_burst_mux: RTL and testbench
=================================

# arb8_burst_mux

Grant-driven burst multiplexer. It sits directly downstream of the 8-input round-robin arbiter and consumes its registered one-hot grant. It collects valid/ready/last streams from 8 source channels and drives the arbiter request vector. It forwards the granted channel's burst to a single shared output stream, then pulses ACK to release the grant so the arbiter can rotate.

## Interface
- DW, 32, data width per channel.
- MAX_BEATS, 256, max beats forwarded per grant before forced release (≥2).
- CNT_W, 9, beat counter width; must satisfy 2^CNT_W > MAX_BEATS.

- CLK  in  1  clock, rising edge.
- RST_N  in  1  reset; asynchronous, active-low.
- S_VALID  in  8  per-channel beat valid; once high, held until accepted.
- S_LAST  in  8  per-channel end-of-burst marker.
- S_DATA  in  8*DW  channel n occupies bits [n*DW +: DW].
- S_READY  out  8  per-channel accept.
- ARB_REQ  out  8  request vector to arbiter.
- ARB_GNT  in  8  registered one-hot grant from arbiter.
- ARB_ACK  out  1  one-cycle release pulse to arbiter.
- M_VALID  out  1  output beat valid.
- M_READY  in  1  output accept.
- M_DATA  out  DW  output data.
- M_LAST  out  1  output end-of-burst.
- M_CH  out  3  source channel index of the current beat.
- BUSY  out  1  high in every state except IDLE.
- TRUNC  out  1  one-cycle pulse when a burst is cut at MAX_BEATS.
- ERR  out  1  sticky protocol error; cleared only by reset.

## Operation
- FSM states: IDLE, XFER, RELEASE, DRAIN.
- **IDLE**
  - ARB_REQ = S_VALID; all other outputs 0.
  - If ARB_GNT != 0:
    - Latch the channel index ch (encode of ARB_GNT) and clear the beat counter.
    - If ARB_GNT is one-hot and S_VALID[ch]=1: go to XFER.
    - Otherwise (not one-hot, or granted channel not valid): set ERR and go to RELEASE with no transfer.
- **XFER**
  - ARB_REQ = 0.
  - Output path is combinational from the granted channel: M_VALID = S_VALID[ch], M_DATA = S_DATA[ch], M_CH = ch.
  - S_READY[ch] = M_READY; S_READY of all other channels = 0.
  - M_LAST = S_LAST[ch] | (cnt == MAX_BEATS-1).
  - Each beat (M_VALID & M_READY) increments cnt.
  - A beat with M_LAST=1 goes to RELEASE.
  - If that beat had S_LAST[ch]=0 (forced cut), TRUNC pulses in the same cycle.
  - The rest of the cut burst is forwarded on a later grant.
- **RELEASE**
  - ARB_ACK = 1 for exactly this cycle; ARB_REQ = 0.
  - Go to DRAIN.
- **DRAIN**
  - ARB_ACK = 0; ARB_REQ = 0.
  - Go to IDLE when ARB_GNT == 0; otherwise stay.
- S_READY is never high outside XFER.
- M_VALID is never high outside XFER.

## Timing
- Reset values: state IDLE, cnt 0, ch 0, ERR 0. All outputs 0, except ARB_REQ, which follows S_VALID in IDLE.
- Reset is asynchronous and takes effect immediately, including mid-burst. Any partial burst is abandoned; no ACK is issued.
- If ARB_GNT is still high after the block leaves reset, it is treated as a fresh grant in IDLE.
- Grant latency, S_VALID[n] rising in IDLE at cycle 0:
  - ARB_GNT[n] high at cycle 1.
  - XFER entered at cycle 2; first beat possible at cycle 2.
- Release, last beat accepted at cycle t:
  - ARB_ACK high at t+1.
  - Arbiter GNT low at t+2 (DRAIN).
  - IDLE and new ARB_REQ at t+3.
  - Next grant at t+4; next first beat at t+5.
- Back-pressure: M_READY low holds cnt and state. Beats are never lost or duplicated.
- Simultaneous S_LAST[ch] and cnt == MAX_BEATS-1 on the same beat: normal end; TRUNC stays 0.
- cnt never exceeds MAX_BEATS-1 and does not wrap within a grant.

## Test plan
- Single channel 2, 3-beat burst (data 0xA,0xB,0xC, last on the 3rd), M_READY=1 → GNT at cycle 1; beats at cycles 2-4 with M_CH=2; ARB_ACK at cycle 5; BUSY low by cycle 7.
- Channels 0 and 5 each present 1-beat bursts continuously → output M_CH sequence 0,5,0,5; each beat separated by the 4-cycle release/regrant overhead; ERR=0.
- MAX_BEATS=4, channel 1 presents a 6-beat burst → first grant: 4 beats, M_LAST on the 4th, TRUNC pulse; second grant: 2 beats, TRUNC=0.
- M_READY toggled 1,0,0,1 during a burst → no beat accepted while low; data order intact; cnt frozen.
- ARB_GNT forced to 8'b00000110 in IDLE → no S_READY asserted, ARB_ACK pulses next cycle, ERR=1 and held until RST_N low.
- RST_N asserted low mid-burst (after 2 of 5 beats) → all outputs 0 asynchronously; after release, the block re-requests and forwards the remaining beats under a new grant.

Source files
------------

// File: rtl/arb8_burst_mux.sv
// Grant-driven burst multiplexer: forwards the granted channel's burst to one
// shared stream, cutting at MAX_BEATS, then pulses ARB_ACK to release the grant.

module arb8_burst_mux_lane #(
  parameter int DW = 32
) (
  input  logic          sel_i,
  input  logic          m_ready_i,
  input  logic [DW-1:0] data_i,
  output logic          s_ready_o,
  output logic [DW-1:0] data_o
);
  assign s_ready_o = sel_i & m_ready_i;
  assign data_o    = sel_i ? data_i : '0;
endmodule

module arb8_burst_mux #(
  parameter int DW        = 32,
  parameter int MAX_BEATS = 256,
  parameter int CNT_W     = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      s_valid_i,
  input  logic [7:0]      s_last_i,
  input  logic [8*DW-1:0] s_data_i,
  output logic [7:0]      s_ready_o,
  output logic [7:0]      arb_req_o,
  input  logic [7:0]      arb_gnt_i,
  output logic            arb_ack_o,
  output logic            m_valid_o,
  input  logic            m_ready_i,
  output logic [DW-1:0]   m_data_o,
  output logic            m_last_o,
  output logic [2:0]      m_ch_o,
  output logic            busy_o,
  output logic            trunc_o,
  output logic            err_o
);
  localparam int NUM_CH = 8;

  typedef enum logic [1:0] {IDLE, XFER, RELEASE, DRAIN} state_e;

  state_e             state_q;
  logic [2:0]         ch_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q;

  logic               xfer, beat, cnt_at_max, gnt_onehot;
  logic [2:0]         gnt_idx;
  logic [NUM_CH-1:0]  lane_sel;
  logic [NUM_CH-1:0][DW-1:0] lane_data;

  // Lowest set bit wins; only matters for a malformed grant, which errors anyway.
  always_comb begin
    gnt_idx = '0;
    for (int i = NUM_CH-1; i >= 0; i--)
      if (arb_gnt_i[i]) gnt_idx = 3'(i);
  end

  assign gnt_onehot = (arb_gnt_i != '0) && ((arb_gnt_i & (arb_gnt_i - 8'd1)) == '0);

  assign xfer       = (state_q == XFER);
  assign cnt_at_max = (cnt_q == CNT_W'(MAX_BEATS-1));
  assign cnt_d      = cnt_q + CNT_W'(1);

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
      assign lane_sel[g] = xfer && (ch_q == 3'(g));
      arb8_burst_mux_lane #(.DW(DW)) u_lane (
        .sel_i     (lane_sel[g]),
        .m_ready_i (m_ready_i),
        .data_i    (s_data_i[g*DW +: DW]),
        .s_ready_o (s_ready_o[g]),
        .data_o    (lane_data[g])
      );
    end
  endgenerate

  always_comb begin
    m_data_o = '0;
    for (int i = 0; i < NUM_CH; i++) m_data_o |= lane_data[i];
  end

  assign m_valid_o = xfer & s_valid_i[ch_q];
  assign m_last_o  = xfer & (s_last_i[ch_q] | cnt_at_max);
  assign beat      = m_valid_o & m_ready_i;
  // A cut is a MAX_BEATS end without the source's own last marker.
  assign trunc_o   = beat & m_last_o & ~s_last_i[ch_q];
  assign m_ch_o    = xfer ? ch_q : 3'd0;
  assign arb_req_o = (state_q == IDLE) ? s_valid_i : 8'd0;
  assign arb_ack_o = (state_q == RELEASE);
  assign busy_o    = (state_q != IDLE);
  assign err_o     = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (arb_gnt_i != '0) begin
          ch_q  <= gnt_idx;
          cnt_q <= '0;
          if (gnt_onehot && s_valid_i[gnt_idx]) state_q <= XFER;
          else begin
            err_q   <= 1'b1;
            state_q <= RELEASE;
          end
        end
        XFER: if (beat) begin
          if (m_last_o) state_q <= RELEASE;
          else          cnt_q   <= cnt_d;
        end
        RELEASE: state_q <= DRAIN;
        DRAIN:   if (arb_gnt_i == '0) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_arb8_burst_mux.sv
// Bench for arb8_burst_mux: behavioural arbiter + per-channel source queues,
// a reset/IDLE vector table, directed corner sequences and a random soak.

module tb_arb8_burst_mux;
  localparam int DW = 32, MAXB = 4, CW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [7:0]      s_valid, s_last, s_ready, arb_req, arb_gnt;
  logic [8*DW-1:0] s_data;
  logic            arb_ack, m_valid, m_ready, m_last, busy, trunc, err;
  logic [DW-1:0]   m_data;
  logic [2:0]      m_ch;

  always #5 clk = ~clk;

  arb8_burst_mux #(.DW(DW), .MAX_BEATS(MAXB), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid_i(s_valid), .s_last_i(s_last), .s_data_i(s_data), .s_ready_o(s_ready),
    .arb_req_o(arb_req), .arb_gnt_i(arb_gnt), .arb_ack_o(arb_ack),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data), .m_last_o(m_last),
    .m_ch_o(m_ch), .busy_o(busy), .trunc_o(trunc), .err_o(err)
  );

  // Behavioural round-robin arbiter: registered one-hot grant held until ACK.
  logic [7:0] arb_q = '0;
  logic [2:0] rr_ptr = 3'd7;
  logic       rr_init = 1'b0, force_en = 1'b0;
  logic [7:0] force_val = '0;
  int         grants = 0;

  function automatic int rr_pick(input logic [7:0] req, input logic [2:0] ptr);
    for (int k = 1; k <= 8; k++)
      if (req[(int'(ptr) + k) % 8]) return (int'(ptr) + k) % 8;
    return -1;
  endfunction

  assign arb_gnt = force_en ? force_val : arb_q;

  always @(posedge clk) begin
    if (arb_ack) arb_q <= '0;
    else if (arb_q == '0 && rr_pick(arb_req, rr_ptr) >= 0) begin
      arb_q  <= 8'd1 << rr_pick(arb_req, rr_ptr);
      rr_ptr <= 3'(rr_pick(arb_req, rr_ptr));
      grants <= grants + 1;
    end
    if (rr_init) rr_ptr <= 3'd7;
  end

  // Source channels: each queue holds {last, data} beats in send order.
  logic [32:0] srcq [8][$];
  int total = 0, passed = 0, acks = 0, gbeats = 0, cyc = 0;
  logic beat_seen, ack_seen, busy_seen, err_seen, beat_last, beat_trunc;
  logic [2:0]  beat_ch;
  logic [31:0] beat_data;
  logic [7:0]  gnt_seen;
  logic        mr_rand = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    else passed++;
  endtask

  task automatic drive_src();
    for (int n = 0; n < 8; n++) begin
      s_valid[n] = srcq[n].size() > 0;
      s_last[n]  = s_valid[n] ? srcq[n][0][32] : 1'b0;
      s_data[n*DW +: DW] = s_valid[n] ? srcq[n][0][31:0] : 32'd0;
    end
  endtask

  task automatic push_burst(input int ch, input int len, input logic [31:0] base, input bit rnd);
    for (int i = 0; i < len; i++)
      srcq[ch].push_back({(i == len-1), rnd ? $urandom() : base + 32'(i)});
  endtask

  // One clock: check at the negedge against the model, then advance past the edge.
  task automatic cycle();
    logic [32:0] front;
    logic        exp_last;
    @(negedge clk);
    ack_seen  = arb_ack;
    busy_seen = busy;
    err_seen  = err;
    gnt_seen  = arb_gnt;
    if (arb_ack) acks++;
    beat_seen = m_valid & m_ready;
    if (m_valid) chk("m_ch_matches_grant", {7'd0, arb_gnt[m_ch] & $onehot(arb_gnt)}, 1);
    if (beat_seen) begin
      if (srcq[m_ch].size() == 0) chk("beat_from_empty_channel", 1, 0);
      else begin
        front    = srcq[m_ch][0];
        exp_last = front[32] | (gbeats == MAXB-1);
        chk("m_data", m_data, front[31:0]);
        chk("m_last", m_last, exp_last);
        chk("trunc_on_beat", trunc, exp_last & ~front[32]);
        chk("s_ready_on_beat", s_ready, 8'd1 << m_ch);
        gbeats = exp_last ? 0 : gbeats + 1;
      end
      beat_ch = m_ch; beat_data = m_data; beat_last = m_last; beat_trunc = trunc;
    end else begin
      chk("s_ready_without_beat", s_ready, 0);
      chk("trunc_without_beat", trunc, 0);
    end
    @(posedge clk); #1;
    if (beat_seen) void'(srcq[beat_ch].pop_front());
    if (mr_rand) m_ready = ($urandom_range(0, 3) != 0);
    drive_src();
    cyc++;
  endtask

  task automatic settle(input int n);
    repeat (n) cycle();
  endtask

  typedef struct {
    logic [7:0] sv;
    logic [7:0] exp_req;
    logic [7:0] exp_rdy;
    logic       exp_mv;
    logic       exp_busy;
  } vec_t;
  vec_t tbl[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc[$];
    int ch_seq[$];
    logic [31:0] dseq[$];
    int budget;
    int g0, a0;

    tbl[0] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    tbl[2] = '{8'h24, 8'h24, 8'h00, 1'b0, 1'b0};
    tbl[3] = '{8'h81, 8'h81, 8'h00, 1'b0, 1'b0};

    rst_n = 1'b0; m_ready = 1'b0; force_en = 1'b1; force_val = '0;
    s_valid = '0; s_last = '0; s_data = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst_outputs", {s_ready, arb_ack, m_valid, m_last, m_ch, busy, trunc, err}, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_arb_req", arb_req, 0);
    s_valid = 8'h81; #1;
    chk("rst_arb_req_follows", arb_req, 8'h81);
    s_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // IDLE vector table (no grant, no edge crossed)
    for (int i = 0; i < 4; i++) begin
      s_valid = tbl[i].sv; s_last = tbl[i].sv; s_data = {8{32'hDEAD_BEEF}};
      #2;
      chk("idle_arb_req", arb_req, tbl[i].exp_req);
      chk("idle_s_ready", s_ready, tbl[i].exp_rdy);
      chk("idle_m_valid_busy", {m_valid, busy}, {tbl[i].exp_mv, tbl[i].exp_busy});
    end
    drive_src();
    force_en = 1'b0; m_ready = 1'b1;
    @(posedge clk); #1;

    // Single channel 2, 3-beat burst: grant latency and release timing
    push_burst(2, 3, 32'hA, 0); drive_src();
    for (int k = 0; k <= 8; k++) begin
      cycle();
      if (k == 1) chk("t1_gnt_cycle1", gnt_seen, 8'h04);
      if (beat_seen) begin bc.push_back(k); chk("t1_m_ch", beat_ch, 2); end
      if (k == 5) chk("t1_ack_cycle5", ack_seen, 1);
      if (k == 7) chk("t1_busy_low_cycle7", busy_seen, 0);
    end
    chk("t1_beat_count", bc.size(), 3);
    if (bc.size() == 3) chk("t1_beat_cycles", {bc[0][15:0], bc[1][15:0], bc[2][15:0]}, {16'd2, 16'd3, 16'd4});

    // Channels 0 and 5 alternate 1-beat bursts
    rr_init = 1'b1; cycle(); rr_init = 1'b0;
    bc.delete();
    for (int i = 0; i < 2; i++) begin push_burst(0, 1, 32'h00 + i, 0); push_burst(5, 1, 32'h50 + i, 0); end
    drive_src();
    budget = 0;
    while (ch_seq.size() < 4 && budget < 60) begin
      cycle(); budget++;
      if (beat_seen) begin ch_seq.push_back(int'(beat_ch)); bc.push_back(cyc); end
    end
    chk("t2_beats_seen", ch_seq.size(), 4);
    if (ch_seq.size() == 4) begin
      chk("t2_ch_order", {ch_seq[0][3:0], ch_seq[1][3:0], ch_seq[2][3:0], ch_seq[3][3:0]}, 16'h0505);
      chk("t2_spacing", {bc[1]-bc[0], bc[2]-bc[1], bc[3]-bc[2]} == {32'd5, 32'd5, 32'd5}, 1);
    end
    chk("t2_err", err, 0);
    settle(4);

    // Channel 1, 6-beat burst cut at MAX_BEATS=4
    push_burst(1, 6, 32'h100, 0); drive_src();
    bc.delete(); dseq.delete();
    budget = 0;
    while (bc.size() < 6 && budget < 60) begin
      cycle(); budget++;
      if (beat_seen) begin bc.push_back({beat_last, beat_trunc}); dseq.push_back(beat_data); end
    end
    chk("t3_beats_seen", bc.size(), 6);
    if (bc.size() == 6) begin
      chk("t3_last_trunc", {bc[0][1:0], bc[1][1:0], bc[2][1:0], bc[3][1:0], bc[4][1:0], bc[5][1:0]},
          12'b00_00_00_11_00_10);
      chk("t3_data_tail", {dseq[4], dseq[5]}, {32'h104, 32'h105});
    end
    settle(4);

    // M_READY 1,0,0,1 during a burst
    push_burst(3, 4, 32'h30, 0); drive_src();
    bc.delete(); dseq.delete();
    for (int k = 0; k <= 10; k++) begin
      cycle();
      if (beat_seen) begin bc.push_back(k); dseq.push_back(beat_data); end
      m_ready = !((k+1) == 3 || (k+1) == 4);
    end
    chk("t4_beat_count", bc.size(), 4);
    if (bc.size() == 4) begin
      chk("t4_beat_cycles", {bc[0][7:0], bc[1][7:0], bc[2][7:0], bc[3][7:0]}, 32'h02050607);
      chk("t4_data_order", {dseq[0][7:0], dseq[1][7:0], dseq[2][7:0], dseq[3][7:0]}, 32'h30313233);
    end
    m_ready = 1'b1;
    settle(3);

    // Malformed grant in IDLE
    force_en = 1'b1; force_val = 8'b0000_0110;
    cycle();
    chk("t5_no_ack_yet", ack_seen, 0);
    force_val = '0;
    cycle();
    chk("t5_ack_next_cycle", ack_seen, 1);
    chk("t5_err_set", err_seen, 1);
    settle(5);
    chk("t5_err_sticky", {err_seen, busy_seen}, 2'b10);
    rst_n = 1'b0; #1;
    chk("t5_err_cleared_by_reset", err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; force_en = 1'b0;
    settle(2);

    // Reset mid-burst after 2 of 5 beats
    push_burst(4, 5, 32'h40, 0); drive_src();
    dseq.delete();
    budget = 0;
    while (dseq.size() < 2 && budget < 30) begin
      cycle(); budget++;
      if (beat_seen) dseq.push_back(beat_data);
    end
    chk("t6_two_beats_before_reset", dseq.size(), 2);
    rst_n = 1'b0; #1;
    chk("t6_async_outputs", {s_ready, arb_ack, m_valid, m_last, m_ch, busy, trunc, err}, 0);
    chk("t6_async_m_data", m_data, 0);
    gbeats = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    dseq.delete();
    budget = 0;
    while (srcq[4].size() > 0 && budget < 40) begin
      cycle(); budget++;
      if (beat_seen) dseq.push_back(beat_data);
    end
    chk("t6_remaining_beats", dseq.size(), 3);
    if (dseq.size() == 3) chk("t6_remaining_data", {dseq[0], dseq[1], dseq[2]}, {32'h42, 32'h43, 32'h44});
    settle(5);

    // Random soak against the source-queue model
    g0 = grants; a0 = acks;
    mr_rand = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        int c;
        c = $urandom_range(0, 7);
        if (srcq[c].size() < 12) push_burst(c, $urandom_range(1, 7), 0, 1);
        drive_src();
      end
      cycle();
    end
    mr_rand = 1'b0; m_ready = 1'b1;
    budget = 0;
    while (budget < 2000) begin
      int pend;
      pend = 0;
      for (int n = 0; n < 8; n++) pend += srcq[n].size();
      if (pend == 0) break;
      cycle(); budget++;
    end
    settle(8);
    for (int n = 0; n < 8; n++) chk("rnd_queue_drained", srcq[n].size(), 0);
    chk("rnd_grants_equal_acks", grants - g0, acks - a0);
    chk("rnd_err", err, 0);
    chk("rnd_idle_at_end", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
